// File: rtl/line_buffer_ctrl_if.sv
// Pixel-stream control and line-RAM sequencing signals between the video input
// stage (master) and line_buffer_ctrl (slave), plus an FSM state debug tap.
interface line_buffer_ctrl_if #(
    parameter int LINE_NUM  = 2,
    parameter int CNT_WIDTH = 12
);
    logic                 I_frame_start;
    logic                 I_pix_vld;
    logic [LINE_NUM-1:0]  O_wr_en;
    logic [LINE_NUM-1:0]  O_rd_en;
    logic                 O_line_rst_n;
    logic                 O_win_vld;
    logic [CNT_WIDTH-1:0] O_col;
    logic [CNT_WIDTH-1:0] O_row;
    logic                 O_busy;
    logic                 O_err;
    logic [1:0]           dbg_state;

    // Handshake: I_pix_vld has no back-pressure. A pixel is consumed on every
    // clock where it is high in FILL/RUN and I_frame_start is low.
    modport master (
        output I_frame_start, I_pix_vld,
        input  O_wr_en, O_rd_en, O_line_rst_n, O_win_vld, O_col, O_row,
               O_busy, O_err, dbg_state
    );

    modport slave (
        input  I_frame_start, I_pix_vld,
        output O_wr_en, O_rd_en, O_line_rst_n, O_win_vld, O_col, O_row,
               O_busy, O_err, dbg_state
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Column/row sequencer for a cascade of LINE_NUM line-shift RAMs feeding a
// (LINE_NUM+1)-row window. Optional sticky protocol error: LINE_BUF_CTRL_ERR_EN.
module line_buffer_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int LINE_NUM   = 2,
    parameter int CNT_WIDTH  = 12
) (
    input  logic             I_CLK,
    input  logic             I_Rst_n,
    line_buffer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] COL_LAST  = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST  = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'(LINE_NUM - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0] row_q, row_d;
    logic                 line_rst_n_q, line_rst_n_d;
    logic                 active;
    logic                 pix_acc;
    logic [LINE_NUM-1:0]  wr_en;
    logic [LINE_NUM-1:0]  rd_en;

    assign active  = (state_q == ST_FILL) || (state_q == ST_RUN);
    // A frame start in the same cycle as a pixel wins; the pixel is dropped.
    assign pix_acc = bus.I_pix_vld && active && !bus.I_frame_start;

    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            line_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            line_rst_n_q <= line_rst_n_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        line_rst_n_d = !bus.I_frame_start;
        if (bus.I_frame_start) begin
            state_d = ST_FILL;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    col_d = '0;
                    row_d = '0;
                end
                ST_FILL, ST_RUN: begin
                    if (pix_acc) begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + CNT_ONE;
                            if (state_q == ST_FILL && row_q == FILL_LAST) begin
                                state_d = ST_RUN;
                            end
                            if (state_q == ST_RUN && row_q == ROW_LAST) begin
                                state_d = ST_DONE;
                                row_d   = '0;
                            end
                        end else begin
                            col_d = col_q + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // RAM k only starts holding valid data once row k has begun streaming in.
    always_comb begin
        wr_en = '0;
        rd_en = '0;
        for (int k = 0; k < LINE_NUM; k++) begin
            wr_en[k] = pix_acc && (row_q >= CNT_WIDTH'(k));
            rd_en[k] = pix_acc && (row_q >= CNT_WIDTH'(k + 1));
        end
    end

`ifdef LINE_BUF_CTRL_ERR_EN
    logic err_q, err_d;

    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q
              | (bus.I_frame_start && active)
              | (bus.I_pix_vld && !active);
    end

    assign bus.O_err = err_q;
`else
    assign bus.O_err = 1'b0;
`endif

    assign bus.O_wr_en      = wr_en;
    assign bus.O_rd_en      = rd_en;
    assign bus.O_win_vld    = pix_acc && (state_q == ST_RUN);
    assign bus.O_line_rst_n = line_rst_n_q;
    assign bus.O_col        = col_q;
    assign bus.O_row        = row_q;
    assign bus.O_busy       = (state_q != ST_IDLE);
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed, table-driven bench for line_buffer_ctrl (4x4 image, 2 line RAMs)
// plus a second 4x3 instance with a single line RAM.
module tb_line_buffer_ctrl;
  localparam int CW = 12;

`ifdef LINE_BUF_CTRL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct {
    logic       fs;
    logic       pv;
    logic [1:0] wr;
    logic [1:0] rd;
    logic       win;
    int         col;
    int         row;
    logic       busy;
    logic       lrst;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_err = 1'b0;
  vec_t px[16];
  vec_t tbl[$];

  always #5 clk = ~clk;

  line_buffer_ctrl_if #(.LINE_NUM(2), .CNT_WIDTH(CW)) bus0 ();
  line_buffer_ctrl_if #(.LINE_NUM(1), .CNT_WIDTH(CW)) bus1 ();

  line_buffer_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .LINE_NUM(2), .CNT_WIDTH(CW)) u_dut0 (
    .I_CLK   (clk),
    .I_Rst_n (rst_n),
    .bus     (bus0.slave)
  );

  line_buffer_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .LINE_NUM(1), .CNT_WIDTH(CW)) u_dut1 (
    .I_CLK   (clk),
    .I_Rst_n (rst_n),
    .bus     (bus1.slave)
  );

  function automatic vec_t mk(logic fs, logic pv, logic [1:0] wr, logic [1:0] rd, logic win,
                              int col, int row, logic busy, logic lrst);
    vec_t v;
    v.fs = fs; v.pv = pv; v.wr = wr; v.rd = rd; v.win = win;
    v.col = col; v.row = row; v.busy = busy; v.lrst = lrst;
    return v;
  endfunction

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input int i, input vec_t v);
    check_eq($sformatf("%s[%0d] wr_en", tag, i), int'(bus0.O_wr_en), int'(v.wr));
    check_eq($sformatf("%s[%0d] rd_en", tag, i), int'(bus0.O_rd_en), int'(v.rd));
    check_eq($sformatf("%s[%0d] win_vld", tag, i), int'(bus0.O_win_vld), int'(v.win));
    check_eq($sformatf("%s[%0d] col", tag, i), int'(bus0.O_col), v.col);
    check_eq($sformatf("%s[%0d] row", tag, i), int'(bus0.O_row), v.row);
    check_eq($sformatf("%s[%0d] busy", tag, i), int'(bus0.O_busy), int'(v.busy));
    check_eq($sformatf("%s[%0d] line_rst_n", tag, i), int'(bus0.O_line_rst_n), int'(v.lrst));
    check_eq($sformatf("%s[%0d] err", tag, i), int'(bus0.O_err), int'(exp_err));
  endtask

  // Drive one vector after the falling edge, check 1 time unit later.
  task automatic step(input string tag, input int i, input vec_t v);
    @(negedge clk);
    bus0.I_frame_start = v.fs;
    bus0.I_pix_vld     = v.pv;
    #1;
    check_vec(tag, i, v);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) step(tag, i, tbl[i]);
  endtask

  task automatic load_full_frame();
    tbl.delete();
    tbl.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    for (int i = 0; i < 16; i++) tbl.push_back(px[i]);
    tbl.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
  endtask

  initial begin
    //            fs pv  wr     rd    win col row busy lrst
    px[0]  = mk(0, 1, 2'b01, 2'b00, 0, 0, 0, 1, 0);
    px[1]  = mk(0, 1, 2'b01, 2'b00, 0, 1, 0, 1, 1);
    px[2]  = mk(0, 1, 2'b01, 2'b00, 0, 2, 0, 1, 1);
    px[3]  = mk(0, 1, 2'b01, 2'b00, 0, 3, 0, 1, 1);
    px[4]  = mk(0, 1, 2'b11, 2'b01, 0, 0, 1, 1, 1);
    px[5]  = mk(0, 1, 2'b11, 2'b01, 0, 1, 1, 1, 1);
    px[6]  = mk(0, 1, 2'b11, 2'b01, 0, 2, 1, 1, 1);
    px[7]  = mk(0, 1, 2'b11, 2'b01, 0, 3, 1, 1, 1);
    px[8]  = mk(0, 1, 2'b11, 2'b11, 1, 0, 2, 1, 1);
    px[9]  = mk(0, 1, 2'b11, 2'b11, 1, 1, 2, 1, 1);
    px[10] = mk(0, 1, 2'b11, 2'b11, 1, 2, 2, 1, 1);
    px[11] = mk(0, 1, 2'b11, 2'b11, 1, 3, 2, 1, 1);
    px[12] = mk(0, 1, 2'b11, 2'b11, 1, 0, 3, 1, 1);
    px[13] = mk(0, 1, 2'b11, 2'b11, 1, 1, 3, 1, 1);
    px[14] = mk(0, 1, 2'b11, 2'b11, 1, 2, 3, 1, 1);
    px[15] = mk(0, 1, 2'b11, 2'b11, 1, 3, 3, 1, 1);

    bus0.I_frame_start = 1'b0;
    bus0.I_pix_vld     = 1'b0;
    bus1.I_frame_start = 1'b0;
    bus1.I_pix_vld     = 1'b0;

    // Reset values while reset is held
    #12;
    check_vec("reset", 0, mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #11 rst_n = 1'b1;

    // Full frame, back-to-back pixels
    load_full_frame();
    run_table("t1");

    // Same frame with a one-cycle gap after every pixel
    tbl.delete();
    tbl.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    for (int i = 0; i < 15; i++) begin
      tbl.push_back(px[i]);
      tbl.push_back(mk(0, 0, 2'b00, 2'b00, 0, px[i+1].col, px[i+1].row, 1, 1));
    end
    tbl.push_back(px[15]);
    tbl.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    run_table("t2");

    // Pixel valid while idle
    step("t4", 0, mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    exp_err = ERR_EN;
    step("t4", 1, mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    step("t4", 2, mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));

    // Mid-frame restart at row 1, col 2; the pixel in that cycle is dropped
    step("t3", 0, mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    for (int i = 0; i < 6; i++) step("t3a", i, px[i]);
    step("t3", 1, mk(1, 1, 2'b00, 2'b00, 0, 2, 1, 1, 1));
    exp_err = ERR_EN;
    for (int i = 0; i < 16; i++) step("t3b", i, px[i]);
    step("t3", 2, mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1));
    step("t3", 3, mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));

    // Asynchronous reset in RUN at row 3
    step("t5", 0, mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    for (int i = 0; i < 13; i++) step("t5a", i, px[i]);
    @(negedge clk);
    bus0.I_pix_vld = 1'b1;
    #1;
    check_vec("t5pre", 0, mk(0, 1, 2'b11, 2'b11, 1, 1, 3, 1, 1));
    #1 rst_n = 1'b0;
    exp_err = 1'b0;
    #1;
    check_vec("t5rst", 0, mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    bus0.I_pix_vld = 1'b0;
    #1 rst_n = 1'b1;
    load_full_frame();
    run_table("t5b");

    // Single line RAM, 3-line image
    @(negedge clk);
    bus1.I_frame_start = 1'b1;
    #1;
    check_eq("t6 busy idle", int'(bus1.O_busy), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus1.I_frame_start = 1'b0;
      bus1.I_pix_vld     = 1'b1;
      #1;
      check_eq($sformatf("t6[%0d] wr_en", i), int'(bus1.O_wr_en), 1);
      check_eq($sformatf("t6[%0d] rd_en", i), int'(bus1.O_rd_en), (i >= 4) ? 1 : 0);
      check_eq($sformatf("t6[%0d] win_vld", i), int'(bus1.O_win_vld), (i >= 4) ? 1 : 0);
      check_eq($sformatf("t6[%0d] col", i), int'(bus1.O_col), i % 4);
      check_eq($sformatf("t6[%0d] row", i), int'(bus1.O_row), i / 4);
      check_eq($sformatf("t6[%0d] busy", i), int'(bus1.O_busy), 1);
    end
    @(negedge clk);
    bus1.I_pix_vld = 1'b0;
    #1;
    check_eq("t6 done busy", int'(bus1.O_busy), 1);
    check_eq("t6 done wr_en", int'(bus1.O_wr_en), 0);
    @(negedge clk);
    #1;
    check_eq("t6 idle busy", int'(bus1.O_busy), 0);
    check_eq("t6 err", int'(bus1.O_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
